// File: rtl/word_lane_serializer.sv
// word_lane_serializer: splits one WORD_W-bit word into NLANES LANE_W-bit beats
// with valid/ready on both sides, first/last markers and a synchronous flush.
`default_nettype none

module word_lane_serializer #(
  parameter int WORD_W    = 32,
  parameter int LANE_W    = 8,
  parameter int MSB_FIRST = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LANE_W-1:0] out_data,
  output logic              out_first,
  output logic              out_last,
  output logic              busy
);

  localparam int NLANES = WORD_W / LANE_W;
  localparam int IDX_W  = (NLANES > 1) ? $clog2(NLANES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NLANES - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t              state, state_nxt;
  logic [WORD_W-1:0]   word_q, word_nxt;
  logic [IDX_W-1:0]    idx, idx_nxt;
  logic                valid_nxt;
  logic [LANE_W-1:0]   data_nxt;
  logic                first_nxt;
  logic                last_nxt;
  logic                accept;
  logic                beat_done;

  function automatic logic [LANE_W-1:0] lane_sel(input logic [WORD_W-1:0] w,
                                                 input logic [IDX_W-1:0]  k);
    int pos;
    pos = (MSB_FIRST != 0) ? (NLANES - 1 - int'(k)) : int'(k);
    return w[pos*LANE_W +: LANE_W];
  endfunction

  // A new word may enter while idle or in the same cycle its predecessor's last beat leaves.
  assign in_ready  = !flush && ((state == IDLE) || (out_valid && out_ready && out_last));
  assign accept    = in_valid && in_ready;
  assign beat_done = out_valid && out_ready;
  assign busy      = (state == SHIFT);

  always_comb begin
    state_nxt = state;
    word_nxt  = word_q;
    idx_nxt   = idx;
    valid_nxt = out_valid;
    data_nxt  = out_data;
    first_nxt = out_first;
    last_nxt  = out_last;

    if (flush) begin
      state_nxt = IDLE;
      idx_nxt   = '0;
      valid_nxt = 1'b0;
      first_nxt = 1'b0;
      last_nxt  = 1'b0;
    end else if (beat_done && (idx != LAST_IDX)) begin
      idx_nxt   = idx + 1'b1;
      data_nxt  = lane_sel(word_q, idx + 1'b1);
      first_nxt = 1'b0;
      last_nxt  = ((idx + 1'b1) == LAST_IDX);
    end else if (accept) begin
      state_nxt = SHIFT;
      word_nxt  = in_data;
      idx_nxt   = '0;
      valid_nxt = 1'b1;
      data_nxt  = lane_sel(in_data, '0);
      first_nxt = 1'b1;
      last_nxt  = 1'b0;
    end else if (beat_done) begin
      state_nxt = IDLE;
      idx_nxt   = '0;
      valid_nxt = 1'b0;
      first_nxt = 1'b0;
      last_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      word_q    <= '0;
      idx       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      state     <= state_nxt;
      word_q    <= word_nxt;
      idx       <= idx_nxt;
      out_valid <= valid_nxt;
      out_data  <= data_nxt;
      out_first <= first_nxt;
      out_last  <= last_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_word_lane_serializer.sv
// tb_word_lane_serializer: directed and random stimulus against a beat-level
// reference model; a second instance covers MSB-first with narrow lanes.
`default_nettype none

module tb_word_lane_serializer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush, in_valid, out_ready;
  logic [31:0] in_data;
  logic        in_ready, out_valid, out_first, out_last, busy;
  logic [7:0]  out_data;

  logic        b_flush, b_in_valid, b_out_ready;
  logic [15:0] b_in_data;
  logic        b_in_ready, b_out_valid, b_out_first, b_out_last, b_busy;
  logic [3:0]  b_out_data;

  int errors = 0;
  int checks = 0;

  // reference model: word held, beat index being presented
  logic        m_busy;
  logic [31:0] m_word;
  int          m_k;

  logic [7:0]  beats[$];
  logic [7:0]  p_data;
  logic        p_first, p_last, p_valid, p_rdy;

  always #5 clk = ~clk;

  word_lane_serializer dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_first(out_first), .out_last(out_last), .busy(busy)
  );

  word_lane_serializer #(.WORD_W(16), .LANE_W(4), .MSB_FIRST(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_first(b_out_first), .out_last(b_out_last), .busy(b_busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_lane(input logic [31:0] w, input int k);
    logic [31:0] sh;
    sh = w >> (8 * k);
    return sh[7:0];
  endfunction

  task automatic model_reset();
    m_busy = 1'b0;
    m_word = '0;
    m_k    = 0;
  endtask

  // One clock: drive, compare all outputs to the model, then advance the model.
  task automatic step(input logic f, input logic iv, input logic [31:0] d, input logic ordy);
    logic m_rdy;
    @(negedge clk);
    flush = f; in_valid = iv; in_data = d; out_ready = ordy;
    #1;
    m_rdy = !f && (!m_busy || (ordy && m_k == 3));
    chk("in_ready", in_ready, m_rdy);
    chk("out_valid", out_valid, m_busy);
    chk("busy", busy, m_busy);
    chk("out_first", out_first, m_busy && m_k == 0);
    chk("out_last", out_last, m_busy && m_k == 3);
    if (m_busy) chk("out_data", out_data, exp_lane(m_word, m_k));
    p_data = out_data; p_first = out_first; p_last = out_last;
    p_valid = out_valid; p_rdy = in_ready;
    if (out_valid && ordy) beats.push_back(out_data);
    @(posedge clk);
    if (f) begin
      m_busy = 1'b0;
      m_k    = 0;
    end else begin
      if (m_busy && ordy) begin
        if (m_k < 3) m_k++;
        else m_busy = 1'b0;
      end
      if (iv && m_rdy) begin
        m_busy = 1'b1;
        m_word = d;
        m_k    = 0;
      end
    end
  endtask

  task automatic chk_beats(input string tag, input logic [31:0] w0, input logic [31:0] w1, input int n);
    logic [7:0] e;
    chk({tag, "_count"}, 64'(beats.size()), 64'(n));
    for (int i = 0; i < n && i < beats.size(); i++) begin
      e = (i < 4) ? exp_lane(w0, i) : exp_lane(w1, i - 4);
      chk(tag, beats[i], e);
    end
  endtask

  logic [3:0] exp_b [4];

  initial begin
    rst_n = 1'b0; flush = 0; in_valid = 0; in_data = '0; out_ready = 0;
    b_flush = 0; b_in_valid = 0; b_in_data = '0; b_out_ready = 0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_first_last", {out_first, out_last}, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_b_valid", b_out_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // single word, no backpressure
    beats.delete();
    step(0, 1, 32'hDDCCBBAA, 1);
    step(0, 0, 0, 1);
    chk("t1_first_on_aa", {p_first, p_data}, {1'b1, 8'hAA});
    repeat (3) step(0, 0, 0, 1);
    chk("t1_last_on_dd", {p_last, p_data}, {1'b1, 8'hDD});
    step(0, 0, 0, 1);
    chk("t1_idle", p_valid, 1'b0);
    chk_beats("t1_beats", 32'hDDCCBBAA, 0, 4);

    // back-to-back words, no bubble
    beats.delete();
    step(0, 1, 32'h44332211, 1);
    repeat (3) begin
      step(0, 1, 32'h88776655, 1);
      chk("t2_ready_low", p_rdy, 1'b0);
    end
    step(0, 1, 32'h88776655, 1);
    chk("t2_ready_on_44", {p_rdy, p_data}, {1'b1, 8'h44});
    repeat (4) step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk_beats("t2_beats", 32'h44332211, 32'h88776655, 8);

    // backpressure while BB presented
    beats.delete();
    step(0, 1, 32'hDDCCBBAA, 1);
    step(0, 0, 0, 1);
    repeat (3) begin
      step(0, 0, 0, 0);
      chk("t3_hold", {p_valid, p_data}, {1'b1, 8'hBB});
    end
    repeat (4) step(0, 0, 0, 1);
    chk_beats("t3_beats", 32'hDDCCBBAA, 0, 4);

    // flush while CC valid
    step(0, 1, 32'hDDCCBBAA, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(1, 1, 32'h12345678, 1);
    chk("t4_flush_on_cc", p_data, 8'hCC);
    step(0, 1, 32'hCAFEF00D, 1);
    chk("t4_after_flush", {p_valid, p_rdy}, 2'b01);
    step(0, 0, 0, 1);
    chk("t4_new_first", {p_first, p_data}, {1'b1, 8'h0D});
    repeat (4) step(0, 0, 0, 1);

    // asynchronous reset mid-word
    step(0, 1, 32'h0BADBEEF, 1);
    step(0, 0, 0, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", out_valid, 1'b0);
    chk("t5_rst_data", out_data, 8'h00);
    chk("t5_rst_busy", {busy, out_first, out_last}, 3'b000);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 1, 32'h76543210, 1);
    step(0, 0, 0, 1);
    chk("t5_restart", {p_first, p_data}, {1'b1, 8'h10});
    repeat (4) step(0, 0, 0, 1);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 20) == 0, ($urandom % 4) != 0, $urandom, ($urandom % 4) != 0);
    end
    step(1, 0, 0, 1);

    // MSB-first, 16-bit word in 4-bit lanes
    exp_b = '{4'hA, 4'h5, 4'hC, 4'h3};
    @(negedge clk);
    b_in_valid = 1'b1; b_in_data = 16'hA5C3; b_out_ready = 1'b1;
    @(negedge clk);
    b_in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      chk("t6_beat", {b_out_valid, b_out_data}, {1'b1, exp_b[i]});
      chk("t6_marks", {b_out_first, b_out_last}, {i == 0, i == 3});
    end
    @(negedge clk);
    #1;
    chk("t6_idle", {b_out_valid, b_busy}, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
